// File: rtl/column_scan_ctrl.sv
// Column scan sequencer for a display driven through an external universal
// shift register. It seeds a one-hot pattern, shifts it one column per dwell
// period, re-seeds at each frame wrap and advances a scroll offset every
// few frames.
//
// state | meaning
// IDLE  | waiting for en, shift register untouched
// LOAD  | one-hot seed loaded, start of first frame
// SCAN  | dwelling on a column, shift issued at end of each dwell
// WRAP  | last column dwell ends, seed reloaded, frame counted
// STOP  | shift register cleared, back to IDLE
//
// Every output is a flop. Decisions are taken one cycle ahead from the
// next-cycle counter value, so the shift/load command sits on sel during
// the very cycle whose closing edge must act on the shift register.
module column_scan_ctrl #(
  parameter int N     = 8,
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 CLR_n,
  input  logic                 en,
  input  logic [DIV_W-1:0]     tick_div,
  input  logic                 dir,
  input  logic                 scroll_en,
  input  logic [7:0]           scroll_div,
  output logic [1:0]           sel,
  output logic [N-1:0]         d,
  output logic                 sr_clr,
  output logic [$clog2(N)-1:0] col_idx,
  output logic [7:0]           scroll_ofs,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_LOAD  = 2'd1;
  localparam logic [1:0] SEL_LEFT  = 2'd2;
  localparam logic [1:0] SEL_RIGHT = 2'd3;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRAP, STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic [7:0]       fcnt_q, fcnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       sel_d;
  logic [N-1:0]     d_d, seed;
  logic             sr_clr_d, fd_d, busy_d;
  logic [CW-1:0]    col_d, col_nx;
  logic [7:0]       ofs_d;
  logic [DIV_W-1:0] dwell_last;
  logic [7:0]       frames_last;

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    dir_d    = dir_q;
    sel_d    = SEL_HOLD;
    d_d      = d;
    sr_clr_d = 1'b0;
    fd_d     = 1'b0;
    col_d    = col_idx;
    ofs_d    = scroll_ofs;
    cnt_nx   = cnt_q;
    col_nx   = col_idx;

    // A zero divider behaves as one.
    dwell_last  = (tick_div == '0) ? '0 : tick_div - DIV_W'(1);
    frames_last = (scroll_div == 8'd0) ? 8'd0 : scroll_div - 8'd1;
    seed        = dir ? {1'b1, {(N-1){1'b0}}} : {{(N-1){1'b0}}, 1'b1};

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LOAD;
          sel_d   = SEL_LOAD;
          d_d     = seed;
          dir_d   = dir;
          col_d   = '0;
          cnt_d   = '0;
        end
      end

      LOAD, SCAN, WRAP: begin
        if (!en) begin
          state_d  = STOP;
          sr_clr_d = 1'b1;
          d_d      = '0;
          col_d    = '0;
          cnt_d    = '0;
          fcnt_d   = 8'd0;
        end else begin
          // A shift cycle (sel non-zero while scanning) ends the dwell;
          // LOAD and WRAP start a fresh frame on column 0.
          if (state_q == SCAN && sel != SEL_HOLD) begin
            cnt_nx = '0;
            col_nx = col_idx + CW'(1);
          end else if (state_q == SCAN) begin
            cnt_nx = cnt_q + DIV_W'(1);
          end else begin
            cnt_nx = '0;
            col_nx = '0;
          end
          cnt_d   = cnt_nx;
          col_d   = col_nx;
          state_d = SCAN;

          if (cnt_nx == dwell_last) begin
            if (col_nx == LAST_COL) begin
              state_d = WRAP;
              sel_d   = SEL_LOAD;
              d_d     = seed;
              dir_d   = dir;
              col_d   = '0;
              fd_d    = 1'b1;
              if (scroll_en) begin
                if (fcnt_q == frames_last) begin
                  ofs_d  = scroll_ofs + 8'd1;
                  fcnt_d = 8'd0;
                end else begin
                  fcnt_d = fcnt_q + 8'd1;
                end
              end
            end else begin
              sel_d = dir_q ? SEL_RIGHT : SEL_LEFT;
            end
          end
        end
      end

      STOP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and all output flops.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fcnt_q     <= 8'd0;
      dir_q      <= 1'b0;
      sel        <= SEL_HOLD;
      d          <= '0;
      sr_clr     <= 1'b0;
      col_idx    <= '0;
      scroll_ofs <= 8'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      dir_q      <= dir_d;
      sel        <= sel_d;
      d          <= d_d;
      sr_clr     <= sr_clr_d;
      col_idx    <= col_d;
      scroll_ofs <= ofs_d;
      frame_done <= fd_d;
      busy       <= busy_d;
    end
  end

endmodule
